// File: rtl/ahbl_splitter_if.sv
// AHB-Lite 1:N splitter bus bundle: upstream master-side signals plus packed per-slave vectors.
// The splitter uses the slave modport; the environment (master and slave models) uses master.
interface ahbl_splitter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) ();
    logic                        src_hready;
    logic                        src_hready_resp;
    logic                        src_hresp;
    logic                        src_hexokay;
    logic [W_ADDR-1:0]           src_haddr;
    logic                        src_hwrite;
    logic [1:0]                  src_htrans;
    logic [2:0]                  src_hsize;
    logic [2:0]                  src_hburst;
    logic [3:0]                  src_hprot;
    logic                        src_hmastlock;
    logic                        src_hexcl;
    logic [W_DATA-1:0]           src_hwdata;
    logic [W_DATA-1:0]           src_hrdata;

    logic [N_PORTS-1:0]          dst_hready;
    logic [N_PORTS-1:0]          dst_hready_resp;
    logic [N_PORTS-1:0]          dst_hresp;
    logic [N_PORTS-1:0]          dst_hexokay;
    logic [N_PORTS*W_ADDR-1:0]   dst_haddr;
    logic [N_PORTS-1:0]          dst_hwrite;
    logic [N_PORTS*2-1:0]        dst_htrans;
    logic [N_PORTS*3-1:0]        dst_hsize;
    logic [N_PORTS*3-1:0]        dst_hburst;
    logic [N_PORTS*4-1:0]        dst_hprot;
    logic [N_PORTS-1:0]          dst_hmastlock;
    logic [N_PORTS-1:0]          dst_hexcl;
    logic [N_PORTS*W_DATA-1:0]   dst_hwdata;
    logic [N_PORTS*W_DATA-1:0]   dst_hrdata;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hexcl, src_hwdata,
               dst_hready_resp, dst_hresp, dst_hexokay, dst_hrdata,
        output src_hready_resp, src_hresp, src_hexokay, src_hrdata,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hexcl, dst_hwdata
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hexcl, src_hwdata,
               dst_hready_resp, dst_hresp, dst_hexokay, dst_hrdata,
        input  src_hready_resp, src_hresp, src_hexokay, src_hrdata,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hexcl, dst_hwdata
    );
endinterface

// File: rtl/ahbl_splitter.sv
// AHB-Lite 1:N splitter: address decode to one slave, data-phase owner tracking, and a
// two-cycle ERROR response for unmapped active transfers.
//
// state   | meaning
// ST_OK   | normal; response from data-phase owner, or idle OKAY
// ST_ERR1 | first ERROR cycle (hready_resp=0, hresp=1)
// ST_ERR2 | second ERROR cycle (hready_resp=1, hresp=1), new address phase decoded
module ahbl_splitter #(
    parameter int                          N_PORTS   = 2,
    parameter int                          W_ADDR    = 32,
    parameter int                          W_DATA    = 32,
    parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = '0,
    parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = '0,
    parameter logic [N_PORTS-1:0]          CONN_MASK = {N_PORTS{1'b1}}
) (
    input logic            clk,
    input logic            rst_n,
    ahbl_splitter_if.slave bus
);
    typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] match, sel_a, sel_act;
    logic [N_PORTS-1:0] sel_d_q, sel_d_d;
    logic               active;

    assign active  = bus.src_htrans[1];
    assign sel_act = sel_a & {N_PORTS{active}};

    // Walk from the top down so the lowest matching index is the last one written.
    always_comb begin
        match = '0;
        sel_a = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            match[i] = ((bus.src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR])
                       && CONN_MASK[i];
            if (match[i]) begin
                sel_a    = '0;
                sel_a[i] = 1'b1;
            end
        end
    end

    assign bus.dst_hready    = {N_PORTS{bus.src_hready}};
    assign bus.dst_haddr     = {N_PORTS{bus.src_haddr}};
    assign bus.dst_hwrite    = {N_PORTS{bus.src_hwrite}};
    assign bus.dst_hsize     = {N_PORTS{bus.src_hsize}};
    assign bus.dst_hburst    = {N_PORTS{bus.src_hburst}};
    assign bus.dst_hprot     = {N_PORTS{bus.src_hprot}};
    assign bus.dst_hmastlock = {N_PORTS{bus.src_hmastlock}};
    assign bus.dst_hexcl     = {N_PORTS{bus.src_hexcl}};
    assign bus.dst_hwdata    = {N_PORTS{bus.src_hwdata}};

    always_comb begin
        bus.dst_htrans = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (sel_act[i]) bus.dst_htrans[2*i +: 2] = bus.src_htrans;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
            sel_d_q <= '0;
        end else begin
            state_q <= state_d;
            sel_d_q <= sel_d_d;
        end
    end

    // ERR1 advances unconditionally; an error never owns a slave data phase.
    always_comb begin
        state_d = state_q;
        sel_d_d = sel_d_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
            sel_d_d = '0;
        end else if (bus.src_hready) begin
            sel_d_d = sel_act;
            state_d = (active && !(|match)) ? ST_ERR1 : ST_OK;
        end
    end

    always_comb begin
        bus.src_hready_resp = 1'b1;
        bus.src_hresp       = 1'b0;
        bus.src_hexokay     = 1'b0;
        bus.src_hrdata      = '0;
        case (state_q)
            ST_ERR1: begin
                bus.src_hready_resp = 1'b0;
                bus.src_hresp       = 1'b1;
            end
            ST_ERR2: begin
                bus.src_hresp       = 1'b1;
            end
            default: begin
                for (int i = 0; i < N_PORTS; i++) begin
                    if (sel_d_q[i]) begin
                        bus.src_hready_resp = bus.dst_hready_resp[i];
                        bus.src_hresp       = bus.dst_hresp[i];
                        bus.src_hexokay     = bus.dst_hexokay[i];
                        bus.src_hrdata      = bus.dst_hrdata[i*W_DATA +: W_DATA];
                    end
                end
            end
        endcase
    end
endmodule
